// File: rtl/sprite_pkg.sv
// Shared sprite-sheet layout definitions.
// Used by the glyph blitter (writer side) and the display-side sprite reader
// so both agree on glyph cell size and sheet arrangement.
package sprite_pkg;

  localparam int GLYPH_W        = 38;  // glyph cell width in pixels
  localparam int GLYPH_H        = 45;  // glyph cell height in pixels
  localparam int GLYPHS_PER_ROW = 6;   // glyph cells per sheet row
  localparam int NUM_GLYPHS     = 26;  // codes at or above this are blank

  typedef logic [4:0] letter_t;        // glyph code
  typedef logic [5:0] glyph_coord_t;   // gx 0..37 / gy 0..44 within a cell
  typedef logic [7:0] sheet_coord_t;   // cell origin on the sheet

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } blit_state_t;

endpackage

// File: rtl/glyph_blitter_if.sv
// Draw-request handshake between game/text logic and the glyph blitter.
//   req_valid_in  : request valid (driven by the requester)
//   req_ready_out : blitter can accept a request
//   letter_in     : glyph code 0-25, 26-31 draws a blank cell
//   x_in, y_in    : framebuffer position of the glyph's top-left pixel
// Signal directions in the names are from the blitter's point of view.
interface glyph_blitter_if;
  import sprite_pkg::*;

  logic        req_valid_in;
  logic        req_ready_out;
  letter_t     letter_in;
  logic [10:0] x_in;
  logic [9:0]  y_in;

  modport master (
    output req_valid_in, letter_in, x_in, y_in,
    input  req_ready_out
  );

  modport slave (
    input  req_valid_in, letter_in, x_in, y_in,
    output req_ready_out
  );

endinterface

// File: rtl/glyph_origin.sv
// Maps a glyph code to the top-left corner of its cell in the sprite sheet.
// Blank codes report the letter-0 origin so address generation stays
// well defined.
//   letter_in   : glyph code
//   sheet_x_out : cell origin column on the sheet
//   sheet_y_out : cell origin row on the sheet
//   blank_out   : code is outside the glyph set
module glyph_origin
  import sprite_pkg::*;
(
  input  letter_t      letter_in,
  output sheet_coord_t sheet_x_out,
  output sheet_coord_t sheet_y_out,
  output logic         blank_out
);

  letter_t code;
  letter_t row;
  letter_t col;

  always_comb begin
    blank_out   = (letter_in >= letter_t'(NUM_GLYPHS));
    code        = blank_out ? '0 : letter_in;
    row         = code / letter_t'(GLYPHS_PER_ROW);
    col         = code - row * letter_t'(GLYPHS_PER_ROW);
    sheet_x_out = sheet_coord_t'(col) * sheet_coord_t'(GLYPH_W);
    sheet_y_out = sheet_coord_t'(row) * sheet_coord_t'(GLYPH_H);
  end

endmodule

// File: rtl/glyph_blitter.sv
// Copies one 38x45 glyph cell from the sprite-sheet ROM into the framebuffer.
//   pixel_clk_in, rst_in : clock, synchronous active-high reset
//   req_if               : draw-request handshake (slave side)
//   sheet_addr_out       : ROM read address, one pixel per cycle while running
//   sheet_data_in        : ROM data, two cycles after the address
//   fb_addr_out/fb_data_out/fb_we_out : framebuffer write port
//   busy_out             : a blit is in progress
//   done_out             : one-cycle pulse after the last write
module glyph_blitter
  import sprite_pkg::*;
#(
  parameter int         SHEET_WIDTH  = 256,
  parameter int         SHEET_HEIGHT = 512,
  parameter int         FB_WIDTH     = 320,
  parameter int         FB_HEIGHT    = 180,
  parameter logic [7:0] KEY_IDX      = 8'd255,
  parameter logic [7:0] BG_IDX       = 8'd0
) (
  input  logic                                       pixel_clk_in,
  input  logic                                       rst_in,
  glyph_blitter_if.slave                             req_if,
  output logic [$clog2(SHEET_WIDTH*SHEET_HEIGHT)-1:0] sheet_addr_out,
  input  logic [7:0]                                 sheet_data_in,
  output logic [$clog2(FB_WIDTH*FB_HEIGHT)-1:0]       fb_addr_out,
  output logic [7:0]                                 fb_data_out,
  output logic                                       fb_we_out,
  output logic                                       busy_out,
  output logic                                       done_out
);

  localparam int SA_W  = $clog2(SHEET_WIDTH*SHEET_HEIGHT);
  localparam int FB_AW = $clog2(FB_WIDTH*FB_HEIGHT);
  // One bit wider than x_in/y_in so x+gx and y+gy never wrap.
  localparam int XS_W  = 12;
  localparam int YS_W  = 11;

  // Per-pixel side information that travels alongside the ROM read.
  typedef struct packed {
    logic             valid;
    logic             clip;
    logic             blank;
    logic [FB_AW-1:0] fb_addr;
  } pix_meta_t;

  blit_state_t  state_q,  state_d;
  letter_t      letter_q, letter_d;
  logic [10:0]  x_q,      x_d;
  logic [9:0]   y_q,      y_d;
  glyph_coord_t gx_q,     gx_d;
  glyph_coord_t gy_q,     gy_d;
  logic         drain_q,  drain_d;
  logic         done_q,   done_d;
  pix_meta_t    meta1_q,  meta1_d;
  pix_meta_t    meta2_q,  meta2_d;

  pix_meta_t    meta0;
  sheet_coord_t sheet_x;
  sheet_coord_t sheet_y;
  logic         blank;
  logic [8:0]   sx, sy;
  logic [XS_W-1:0] fx;
  logic [YS_W-1:0] fy;

  glyph_origin u_origin (
    .letter_in   (letter_q),
    .sheet_x_out (sheet_x),
    .sheet_y_out (sheet_y),
    .blank_out   (blank)
  );

  // Address generation for the pixel currently being issued.
  always_comb begin
    sx = {1'b0, sheet_x} + 9'(gx_q);
    sy = {1'b0, sheet_y} + 9'(gy_q);
    fx = {1'b0, x_q} + XS_W'(gx_q);
    fy = {1'b0, y_q} + YS_W'(gy_q);

    sheet_addr_out = SA_W'(sy) * SA_W'(SHEET_WIDTH) + SA_W'(sx);

    meta0.valid   = (state_q == RUN);
    meta0.clip    = (fx >= XS_W'(FB_WIDTH)) || (fy >= YS_W'(FB_HEIGHT));
    meta0.blank   = blank;
    meta0.fb_addr = FB_AW'(fy) * FB_AW'(FB_WIDTH) + FB_AW'(fx);
  end

  always_comb begin
    // NOTE: every signal gets a default here so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    letter_d = letter_q;
    x_d      = x_q;
    y_d      = y_q;
    gx_d     = gx_q;
    gy_d     = gy_q;
    drain_d  = drain_q;
    done_d   = 1'b0;
    // Two stages match the ROM's two-cycle read latency.
    meta1_d  = meta0;
    meta2_d  = meta1_q;

    case (state_q)
      IDLE: begin
        if (req_if.req_valid_in) begin
          letter_d = req_if.letter_in;
          x_d      = req_if.x_in;
          y_d      = req_if.y_in;
          gx_d     = '0;
          gy_d     = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (gx_q == glyph_coord_t'(GLYPH_W - 1)) begin
          gx_d = '0;
          if (gy_q == glyph_coord_t'(GLYPH_H - 1)) begin
            gy_d    = '0;
            drain_d = 1'b0;
            state_d = DRAIN;
          end else begin
            gy_d = gy_q + 1'b1;
          end
        end else begin
          gx_d = gx_q + 1'b1;
        end
      end
      DRAIN: begin
        // Second drain cycle: the last pixel is on the write port now,
        // so done follows it on the next cycle.
        drain_d = 1'b1;
        if (drain_q) begin
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk_in) begin
    // NOTE: reset is sampled on the clock edge only; a blit in flight is
    // abandoned by clearing the state and the pipeline valids together.
    if (rst_in) begin
      state_q  <= IDLE;
      letter_q <= '0;
      x_q      <= '0;
      y_q      <= '0;
      gx_q     <= '0;
      gy_q     <= '0;
      drain_q  <= 1'b0;
      done_q   <= 1'b0;
      meta1_q  <= '0;
      meta2_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the
      // pre-edge values regardless of statement order.
      state_q  <= state_d;
      letter_q <= letter_d;
      x_q      <= x_d;
      y_q      <= y_d;
      gx_q     <= gx_d;
      gy_q     <= gy_d;
      drain_q  <= drain_d;
      done_q   <= done_d;
      meta1_q  <= meta1_d;
      meta2_q  <= meta2_d;
    end
  end

  assign req_if.req_ready_out = (state_q == IDLE);
  assign busy_out             = (state_q != IDLE);
  assign done_out             = done_q;

  // Blank cells ignore the ROM and the transparency key entirely.
  assign fb_addr_out = meta2_q.fb_addr;
  assign fb_we_out   = meta2_q.valid && !meta2_q.clip &&
                       (meta2_q.blank || (sheet_data_in != KEY_IDX));
  assign fb_data_out = (meta2_q.valid && !meta2_q.blank) ? sheet_data_in : BG_IDX;

endmodule

// File: tb/tb_glyph_blitter.sv
// Self-checking bench for glyph_blitter: scoreboard of expected framebuffer
// writes, plus cycle-exact checks of ROM addressing, done and ready timing.
module tb_glyph_blitter;
  import sprite_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [16:0] sheet_addr;
  logic [7:0]  sheet_data;
  logic [15:0] fb_addr;
  logic [7:0]  fb_data;
  logic        fb_we;
  logic        busy;
  logic        done;

  glyph_blitter_if bif ();

  glyph_blitter dut (
    .pixel_clk_in   (clk),
    .rst_in         (rst),
    .req_if         (bif),
    .sheet_addr_out (sheet_addr),
    .sheet_data_in  (sheet_data),
    .fb_addr_out    (fb_addr),
    .fb_data_out    (fb_data),
    .fb_we_out      (fb_we),
    .busy_out       (busy),
    .done_out       (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int last_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ROM model: two-cycle read latency; returns the low address byte
  // (never 255 inside any glyph cell) or 255 everywhere in key mode.
  bit         rom_key = 1'b0;
  logic [7:0] rom_q1  = '0;
  always @(posedge clk) begin
    rom_q1     <= rom_key ? 8'd255 : sheet_addr[7:0];
    sheet_data <= rom_q1;
  end

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;
  wr_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int model_saddr(int l, int k);
    int code = (l >= 26) ? 0 : l;
    int row  = code / 6;
    int col  = code % 6;
    return (38 * col + k % 38) + (45 * row + k / 38) * 256;
  endfunction

  task automatic push_expected(int l, int x, int y, bit key);
    bit blank = (l >= 26);
    for (int k = 0; k < 1710; k++) begin
      int fx = x + k % 38;
      int fy = y + k / 38;
      int d  = blank ? 0 : (key ? 255 : (model_saddr(l, k) & 255));
      wr_t e;
      if (fx < 320 && fy < 180 && (blank || d != 255)) begin
        e.addr = fy * 320 + fx;
        e.data = d;
        e.cyc  = 3 + k;
        exp_q.push_back(e);
      end
    end
  endtask

  // Call at a negedge with the DUT idle. Cycle c below is sampled just
  // after edge T+c-1, i.e. it is "cycle T+c" relative to accept edge T.
  task automatic run_blit(input int l, input int x, input int y, input bit key,
                          input int exp_writes, input bit hold,
                          input int nl, input int nx, input int ny,
                          input int abort_at);
    int wr_cnt   = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    exp_q.delete();
    push_expected(l, x, y, key);
    rom_key          = key;
    bif.req_valid_in = 1'b1;
    bif.letter_in    = letter_t'(l);
    bif.x_in         = 11'(x);
    bif.y_in         = 10'(y);
    @(posedge clk);
    #1 last_acc = cyc;
    for (int c = 1; c <= 1714; c++) begin
      @(negedge clk);
      if (c <= 1710) check("sheet_addr", 32'(sheet_addr), 32'(model_saddr(l, c - 1)));
      if (c == 1) check("busy_after_accept", 32'(busy), 1);
      if (fb_we) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_write", 32'(fb_addr), 32'hFFFF_FFFF);
        end else begin
          wr_t e = exp_q.pop_front();
          check("write_addr_data", {8'd0, fb_addr, fb_data}, 32'((e.addr << 8) | e.data));
          check("write_cycle", 32'(c), 32'(e.cyc));
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = c;
      end
      if (c == 1713) check("ready_low_at_done", 32'(bif.req_ready_out), 0);
      if (c == 1714) check("ready_back", 32'(bif.req_ready_out), 1);
      if (c == 1) begin
        if (hold) begin
          bif.letter_in = letter_t'(nl);
          bif.x_in      = 11'(nx);
          bif.y_in      = 10'(ny);
        end else begin
          bif.req_valid_in = 1'b0;
        end
      end
      if (c == abort_at) begin
        int we_after   = 0;
        int done_after = 0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_we", 32'(fb_we), 0);
        check("rst_ready", 32'(bif.req_ready_out), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_sheet_addr", 32'(sheet_addr), 0);
        check("rst_fb_addr", 32'(fb_addr), 0);
        rst = 1'b0;
        for (int i = 0; i < 1800; i++) begin
          @(negedge clk);
          if (fb_we) we_after++;
          if (done) done_after++;
        end
        check("rst_no_writes", 32'(we_after), 0);
        check("rst_no_done", 32'(done_after), 0);
        exp_q.delete();
        return;
      end
    end
    check("write_count", 32'(wr_cnt), 32'(exp_writes));
    check("scoreboard_left", 32'(exp_q.size()), 0);
    check("done_pulses", 32'(done_cnt), 1);
    check("done_cycle", 32'(done_cyc), 1713);
  endtask

  initial begin
    int prev_acc;
    bif.req_valid_in = 1'b0;
    bif.letter_in    = '0;
    bif.x_in         = '0;
    bif.y_in         = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_we", 32'(fb_we), 0);
    check("reset_done", 32'(done), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_sheet_addr", 32'(sheet_addr), 0);
    check("reset_fb_addr", 32'(fb_addr), 0);
    check("reset_fb_data", 32'(fb_data), 0);
    rst = 1'b0;
    @(negedge clk);
    check("reset_ready", 32'(bif.req_ready_out), 1);

    // Letter 0 at the origin.
    run_blit(0, 0, 0, 1'b0, 1710, 1'b0, 0, 0, 0, 0);
    // Letter 7 at (10,20) with the next request held valid throughout,
    // and different inputs presented while busy.
    run_blit(7, 10, 20, 1'b0, 1710, 1'b1, 2, 50, 60, 0);
    prev_acc = last_acc;
    run_blit(2, 50, 60, 1'b0, 1710, 1'b0, 0, 0, 0, 0);
    check("b2b_accept_gap", 32'(last_acc - prev_acc), 1714);
    // Clipped at the bottom-right corner.
    run_blit(3, 300, 170, 1'b0, 200, 1'b0, 0, 0, 0, 0);
    // Blank cell with an all-key ROM: nothing suppressed.
    run_blit(26, 0, 0, 1'b1, 1710, 1'b0, 0, 0, 0, 0);
    // Fully transparent glyph.
    run_blit(5, 0, 0, 1'b1, 0, 1'b0, 0, 0, 0, 0);
    // Reset while pixel 500 is being issued.
    run_blit(0, 0, 0, 1'b0, 1710, 1'b0, 0, 0, 0, 501);
    // Blitter usable again after the abort.
    @(negedge clk);
    run_blit(9, 100, 40, 1'b0, 1710, 1'b0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
